// File: rtl/gpu_pixel_fetcher_pkg.sv
// Shared definitions for the pixel fetcher: display mode codes, fetch FSM
// states and the bits-per-pixel / pixels-per-byte mapping.
package gpu_pixel_fetcher_pkg;

  localparam logic [1:0] GPU_MODE_1BPP = 2'b00;
  localparam logic [1:0] GPU_MODE_2BPP = 2'b01;
  localparam logic [1:0] GPU_MODE_4BPP = 2'b10;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    WAIT_LINE  = 2'd1,
    FETCH      = 2'd2,
    DONE       = 2'd3
  } fetch_state_e;

  // Reserved mode code 2'b11 falls back to 1bpp.
  function automatic logic [3:0] ppb_of(input logic [1:0] mode);
    case (mode)
      GPU_MODE_2BPP: ppb_of = 4'd4;
      GPU_MODE_4BPP: ppb_of = 4'd2;
      default:       ppb_of = 4'd8;
    endcase
  endfunction

  function automatic logic [2:0] bpp_of(input logic [1:0] mode);
    case (mode)
      GPU_MODE_2BPP: bpp_of = 3'd2;
      GPU_MODE_4BPP: bpp_of = 3'd4;
      default:       bpp_of = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/gpu_fetch_fifo.sv
// Synchronous byte FIFO with flush; flush takes priority over push and pop.
module gpu_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty_o   = (count_q == {CW{1'b0}});
  assign full_o    = (count_q == CW'(DEPTH));
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_o | do_pop_s);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {W{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else if (flush_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/gpu_pixel_fetcher.sv
// Pixel-clock framebuffer fetcher: VRAM reads -> prefetch FIFO -> pixel unpacker.
// Optional build macro GPU_FETCH_DOUBLE_SCAN_EN fetches each source line twice.
module gpu_pixel_fetcher
  import gpu_pixel_fetcher_pkg::*;
#(
  parameter int H_PIXELS   = 160,
  parameter int V_LINES    = 120,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_pixel_i,
  input  logic        rst_n,
  input  logic [14:0] fb_base_addr_i,
  input  logic [1:0]  gpu_mode_i,
  input  logic        frame_start_i,
  input  logic        line_start_i,
  input  logic        pixel_req_i,
  output logic [3:0]  pixel_index_o,
  output logic        pixel_valid_o,
  output logic        underrun_o,
  output logic [14:0] vram_rd_addr_o,
  output logic        vram_rd_en_o,
  input  logic [7:0]  vram_rd_data_i
);

  localparam int              LCW     = $clog2(V_LINES + 1);
  localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LCW-1:0]  V_LAST  = LCW'(V_LINES);
  localparam logic [14:0]     BPL1    = 15'(H_PIXELS / 8);
  localparam logic [CW:0]     DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  fetch_state_e   state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [14:0]    line_addr_q, line_addr_d;
  logic [LCW-1:0] line_cnt_q, line_cnt_d;
  logic [14:0]    cur_addr_q, cur_addr_d;
  logic [14:0]    bytes_left_q, bytes_left_d;
  logic           rd_en_q, rd_en_d;
  logic [14:0]    rd_addr_q, rd_addr_d;
  logic           ret_q;
  logic           drop_q, drop_d;
  logic           underrun_q, underrun_d;
  logic [7:0]     sh_q, sh_d;
  logic [3:0]     spx_q, spx_d;
`ifdef GPU_FETCH_DOUBLE_SCAN_EN
  logic           phase_q, phase_d;
`endif

  logic [14:0]    bpl_s;
  logic           flush_s;
  logic           pop_s;
  logic           push_s;
  logic [7:0]     fifo_data_s;
  logic [CW-1:0]  fifo_count_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic [CW:0]    outstanding_s;
  logic           pixel_valid_s;
  logic           consume_s;
  logic [3:0]     head_s;

  assign push_s        = ret_q & ~drop_q;
  assign outstanding_s = {1'b0, fifo_count_s} + (CW + 1)'(rd_en_q) + (CW + 1)'(ret_q);
  assign pixel_valid_s = (spx_q != 4'd0);
  assign consume_s     = pixel_req_i & pixel_valid_s;

  gpu_fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk_i   (clk_pixel_i),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .data_i  (vram_rd_data_i),
    .pop_i   (pop_s),
    .flush_i (flush_s),
    .data_o  (fifo_data_s),
    .count_o (fifo_count_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Bytes per line for the mode latched at frame start.
  always_comb begin
    case (mode_q)
      GPU_MODE_2BPP: bpl_s = BPL1 << 1;
      GPU_MODE_4BPP: bpl_s = BPL1 << 2;
      default:       bpl_s = BPL1;
    endcase
  end

  // Line/frame sequencing and read issue; frame_start outranks line_start.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    line_addr_d  = line_addr_q;
    line_cnt_d   = line_cnt_q;
    cur_addr_d   = cur_addr_q;
    bytes_left_d = bytes_left_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    drop_d       = 1'b0;
    flush_s      = 1'b0;
`ifdef GPU_FETCH_DOUBLE_SCAN_EN
    phase_d      = phase_q;
`endif
    if (frame_start_i) begin
      mode_d      = gpu_mode_i;
      line_addr_d = fb_base_addr_i;
      line_cnt_d  = {LCW{1'b0}};
      state_d     = WAIT_LINE;
      flush_s     = 1'b1;
      drop_d      = rd_en_q;
`ifdef GPU_FETCH_DOUBLE_SCAN_EN
      phase_d     = 1'b0;
`endif
    end else if (line_start_i && (state_q == WAIT_LINE || state_q == FETCH)) begin
      flush_s = 1'b1;
      drop_d  = rd_en_q;
      if (line_cnt_q == V_LAST) begin
        // Only reachable by aborting the final line mid-fetch.
        state_d = DONE;
      end else begin
        state_d      = FETCH;
        cur_addr_d   = line_addr_q;
        bytes_left_d = bpl_s;
`ifdef GPU_FETCH_DOUBLE_SCAN_EN
        phase_d = ~phase_q;
        if (phase_q) begin
          line_addr_d = line_addr_q + bpl_s;
          line_cnt_d  = line_cnt_q + 1'b1;
        end else begin
          line_addr_d = line_addr_q;
        end
`else
        line_addr_d = line_addr_q + bpl_s;
        line_cnt_d  = line_cnt_q + 1'b1;
`endif
      end
    end else if (state_q == FETCH) begin
      if (bytes_left_q == 15'd0) begin
        state_d = (line_cnt_q == V_LAST) ? DONE : WAIT_LINE;
      end else if ((outstanding_s < DEPTH_C) && !fifo_full_s) begin
        rd_en_d      = 1'b1;
        rd_addr_d    = cur_addr_q;
        cur_addr_d   = cur_addr_q + 15'd1;
        bytes_left_d = bytes_left_q - 15'd1;
      end else begin
        rd_en_d = 1'b0;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Shifter load/advance and sticky underrun.
  always_comb begin
    sh_d       = sh_q;
    spx_d      = spx_q;
    pop_s      = 1'b0;
    underrun_d = underrun_q;
    if (flush_s) begin
      sh_d  = 8'd0;
      spx_d = 4'd0;
    end else if (((spx_q == 4'd0) || (consume_s && spx_q == 4'd1)) && !fifo_empty_s) begin
      pop_s = 1'b1;
      sh_d  = fifo_data_s;
      spx_d = ppb_of(mode_q);
    end else if (consume_s) begin
      sh_d  = sh_q << bpp_of(mode_q);
      spx_d = spx_q - 4'd1;
    end else begin
      sh_d = sh_q;
    end
    if (frame_start_i) begin
      underrun_d = 1'b0;
    end else if (pixel_req_i && !pixel_valid_s) begin
      underrun_d = 1'b1;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // Palette index at the MSB end of the shifter.
  always_comb begin
    case (mode_q)
      GPU_MODE_2BPP: head_s = {2'b00, sh_q[7:6]};
      GPU_MODE_4BPP: head_s = sh_q[7:4];
      default:       head_s = {3'b000, sh_q[7]};
    endcase
  end

  assign pixel_valid_o  = pixel_valid_s;
  assign pixel_index_o  = pixel_valid_s ? head_s : 4'd0;
  assign underrun_o     = underrun_q;
  assign vram_rd_en_o   = rd_en_q;
  assign vram_rd_addr_o = rd_addr_q;

  // State and datapath registers.
  always_ff @(posedge clk_pixel_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH_IDLE;
      mode_q       <= GPU_MODE_1BPP;
      line_addr_q  <= 15'd0;
      line_cnt_q   <= {LCW{1'b0}};
      cur_addr_q   <= 15'd0;
      bytes_left_q <= 15'd0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= 15'd0;
      ret_q        <= 1'b0;
      drop_q       <= 1'b0;
      underrun_q   <= 1'b0;
      sh_q         <= 8'd0;
      spx_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      line_addr_q  <= line_addr_d;
      line_cnt_q   <= line_cnt_d;
      cur_addr_q   <= cur_addr_d;
      bytes_left_q <= bytes_left_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      ret_q        <= rd_en_q;
      drop_q       <= drop_d;
      underrun_q   <= underrun_d;
      sh_q         <= sh_d;
      spx_q        <= spx_d;
    end
  end

`ifdef GPU_FETCH_DOUBLE_SCAN_EN
  // Selects first or repeat scan of the current source line.
  always_ff @(posedge clk_pixel_i or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end
`endif

endmodule
